// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use interlock, taken-branch
// wrong-path flush, and start/ready sequencing of the multi-cycle mult/div unit.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [4:0]       fd_rs1,
  input  logic [4:0]       fd_rs2,
  input  logic             fd_uses_rs2,
  input  logic [4:0]       dx_rd,
  input  logic             dx_is_load,
  input  logic             dx_is_md,
  input  logic             br_taken,
  input  logic             md_ready,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             xm_flush,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] md_cycles
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] md_cycles_q, md_cycles_d;
  logic             md_timeout_q, md_timeout_d;

  logic load_use;
  logic md_release;

  // Register 0 is hard-wired, so a load targeting it can never create a hazard.
  assign load_use = dx_is_load && (dx_rd != 5'd0) &&
                    ((dx_rd == fd_rs1) || (fd_uses_rs2 && (dx_rd == fd_rs2)));

  // Ready and timeout both release; ready wins, so a coincident ready is not a timeout.
  assign md_release = md_ready || (cnt_q == TIMEOUT_VAL);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      md_cycles_q  <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      md_cycles_q  <= md_cycles_d;
      md_timeout_q <= md_timeout_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    md_cycles_d  = md_cycles_q;
    md_timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (dx_is_md) begin
          state_d = ST_MD_BUSY;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_MD_BUSY: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (md_release) begin
          state_d      = ST_IDLE;
          md_cycles_d  = cnt_q;
          md_timeout_d = !md_ready;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_en    = 1'b1;
    fd_en    = 1'b1;
    dx_en    = 1'b1;
    xm_en    = 1'b1;
    mw_en    = 1'b1;
    fd_flush = 1'b0;
    dx_flush = 1'b0;
    xm_flush = 1'b0;
    md_start = 1'b0;
    md_busy  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (dx_is_md) begin
          md_start = 1'b1;
          pc_en    = 1'b0;
          fd_en    = 1'b0;
          dx_en    = 1'b0;
          xm_flush = 1'b1;
        end else if (br_taken) begin
          fd_flush = 1'b1;
          dx_flush = 1'b1;
        end else if (load_use) begin
          pc_en    = 1'b0;
          fd_en    = 1'b0;
          dx_flush = 1'b1;
        end
      end
      ST_MD_BUSY: begin
        // D/X holds the MD instruction, so branch and load-use are not considered here.
        md_busy = 1'b1;
        if (!md_release) begin
          pc_en    = 1'b0;
          fd_en    = 1'b0;
          dx_en    = 1'b0;
          xm_flush = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign md_timeout = md_timeout_q;
  assign md_cycles  = md_cycles_q;

endmodule
